// File: rtl/phys_reg_free_list_if.sv
// Commit notification bundle published by writeback/commit.
// Consumers subscribe through the sub modport.
interface CommitNotif #(
  parameter int unsigned p_phys_addr_bits = 6,
  parameter int unsigned p_seq_num_bits   = 5
);
  logic                        val;
  logic                        wen;
  logic [p_seq_num_bits-1:0]   seq_num;
  logic [4:0]                  areg;
  logic [p_phys_addr_bits-1:0] preg;
  logic [p_phys_addr_bits-1:0] ppreg;

  modport pub (output val, output wen, output seq_num, output areg, output preg, output ppreg);
  modport sub (input val, input wen, input seq_num, input areg, input preg, input ppreg);
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers: pops to rename, reclaims the previous
// preg of each committed write. Non-power-of-two depth with an explicit wrap bit.
module phys_reg_free_list #(
  parameter int unsigned p_phys_addr_bits = 6,
  parameter int unsigned p_seq_num_bits   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_en,
  output logic                        alloc_rdy,
  output logic [p_phys_addr_bits-1:0] alloc_preg,
  output logic [p_phys_addr_bits:0]   num_free,
  CommitNotif.sub                     commit
);

  localparam int unsigned AW              = p_phys_addr_bits;
  localparam int unsigned p_num_phys_regs = 2 ** p_phys_addr_bits;
  localparam int unsigned p_depth         = p_num_phys_regs - 32;
  localparam int unsigned IdxW            = $clog2(p_depth);

  logic [AW-1:0] entry_q [p_depth];
  logic [AW:0]   head_q, head_d;
  logic [AW:0]   tail_q, tail_d;

  logic empty, full, pop, push_req, push;

  // Fields of the bundle this block does not consume.
  logic [p_seq_num_bits-1:0] unused_seq_num;
  logic                      unused_commit;
  assign unused_seq_num = commit.seq_num;
  assign unused_commit  = ^{commit.areg, commit.preg};

  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(p_depth - 1)) begin
      return {~p[AW], {AW{1'b0}}};
    end
    return p + (AW+1)'(1);
  endfunction

  always_comb begin
    empty    = (head_q == tail_q);
    full     = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    pop      = alloc_en && !empty;
    push_req = commit.val && commit.wen;
    // A full list can still accept a push in the same cycle that it pops.
    push     = push_req && (!full || pop);
    head_d   = pop  ? ptr_inc(head_q) : head_q;
    tail_d   = push ? ptr_inc(tail_q) : tail_q;
  end

  always_comb begin
    alloc_rdy  = !empty;
    alloc_preg = entry_q[head_q[IdxW-1:0]];
    if (head_q[AW] == tail_q[AW]) begin
      num_free = {1'b0, tail_q[AW-1:0]} - {1'b0, head_q[AW-1:0]};
    end else begin
      num_free = (AW+1)'(p_depth) - {1'b0, head_q[AW-1:0]} + {1'b0, tail_q[AW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= {1'b1, {AW{1'b0}}};
      for (int i = 0; i < int'(p_depth); i++) begin
        entry_q[i] <= AW'(32 + i);
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (push) begin
        entry_q[tail_q[IdxW-1:0]] <= commit.ppreg;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && push_req && full && !pop) begin
      $error("phys_reg_free_list: push while full, ppreg %0d dropped", commit.ppreg);
    end
  end
`endif

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular free list of physical register specifiers for the renaming front end. It hands out free pregs to rename, one per cycle. It reclaims a preg when the writeback/commit unit broadcasts a committed write: the committed instruction's previous preg (`ppreg`) is returned to the list. It consumes the `CommitNotif` that writeback publishes, and it sits beside the rename table in decode/issue.

## Interface
Parameters:
- `p_phys_addr_bits`, default 6: width of a physical register specifier. Must be at least 6.
- `p_seq_num_bits`, default 5: width of the sequence number. Passed through to the `CommitNotif` type only.
- Derived localparam `p_num_phys_regs` = 2**`p_phys_addr_bits`.
- Derived localparam `p_depth` = `p_num_phys_regs` − 32. This is the queue capacity.

Ports:
- `clk`, input, 1: the single clock. All state updates on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `alloc_en`, input, 1: rename consumes `alloc_preg` this cycle. Honored only when `alloc_rdy` is 1.
- `alloc_rdy`, output, 1: the list is non-empty.
- `alloc_preg`, output, `p_phys_addr_bits`: preg at the head of the list.
- `num_free`, output, `p_phys_addr_bits`+1: current occupancy of the list.
- `commit`, `CommitNotif.sub`: commit notification bundle. Only `val`, `wen` and `ppreg` are used; all other fields are ignored.

## Operation
- Storage is `p_depth` entries of `p_phys_addr_bits` each.
- Pointers:
  - `head` and `tail` are each `p_phys_addr_bits`+1 bits wide: `p_phys_addr_bits` bits of index plus one wrap bit.
  - Index arithmetic wraps at `p_depth`. It is not a power-of-two wrap unless `p_depth` happens to be one.
  - When the index would pass `p_depth`−1, it returns to 0 and the wrap bit toggles.
- Empty means `head` == `tail` (all bits). Full means the indices are equal and the wrap bits differ.
- `num_free` = `tail` − `head`, corrected for the non-power-of-two wrap. It ranges from 0 to `p_depth`.
- Pop occurs when `alloc_en && alloc_rdy`: `head` advances by one.
- Push occurs when `commit.val && commit.wen`:
  - `entry[tail]` is written with `commit.ppreg` and `tail` advances by one.
  - A commit with `wen`=0 (including any write to x0) pushes nothing.
- Simultaneous push and pop are both performed, and `num_free` is unchanged.
- No bypass: a preg pushed in cycle N is allocatable no earlier than cycle N+1.
- Push while full is an illegal upstream condition.
  - The push is dropped and the state does not change.
  - A non-synthesis `$error` fires.
- Pop while empty cannot occur, because `alloc_en` is masked by `alloc_rdy`.
- No duplicate-free detection is performed.

## Timing
- Reset values:
  - `head` = 0, `tail` = 0 with its wrap bit = 1, so the list is full.
  - `entry[i]` = 32 + i for i in 0..`p_depth`−1. Pregs 0..31 hold the initial architectural mapping.
  - Outputs after reset: `alloc_rdy` = 1, `alloc_preg` = 32, `num_free` = `p_depth`.
- A reset asserted mid-operation discards all in-flight state and restores exactly the reset image in the following cycle. A commit presented during a reset cycle is ignored.
- `alloc_rdy`, `alloc_preg` and `num_free` are functions of registered state only. There is no combinational path from `alloc_en` or `commit`.
- The pop takes effect at the posedge ending the cycle in which it is requested. The next head appears on `alloc_preg` in the following cycle.
- Allocation throughput is one preg per cycle. Reclaim throughput is one preg per cycle.
- Latency from commit to allocatable is 1 cycle.

## Test plan
All scenarios use `p_phys_addr_bits`=6, so `p_depth`=32.
- Reset, then hold `alloc_en`=1 for 32 cycles:
  - `alloc_preg` reads 32, 33, …, 63 on consecutive cycles.
  - `alloc_rdy` = 0 and `num_free` = 0 on the 33rd cycle.
- From empty, commit with `val`=1, `wen`=1, `ppreg`=7 in cycle N:
  - `alloc_rdy` = 0 in cycle N and `alloc_rdy` = 1 with `alloc_preg` = 7 in cycle N+1.
  - If `alloc_en`=1 is held throughout, the pop happens in N+1 and `num_free` returns to 0 in N+2.
- After reset, pop 5 entries, then present commit `val`=1 with `wen`=0 and `ppreg`=9: `num_free` stays at 27.
- Full wrap-around:
  - Allocate 32, free 40..71 mod 64 in order, then allocate 32 again.
  - The output order matches the free order, and `num_free` tracks exactly across the index-31→0 wrap.
- Simultaneous pop and push each cycle for 50 cycles from the reset state: `num_free` stays at 32 throughout, and each pushed value emerges exactly 32 pops later.
- Reset mid-stream with 10 entries allocated:
  - The next cycle shows `num_free` = 32 and `alloc_preg` = 32.
  - A commit presented during the reset cycle is not enqueued.
